// File: rtl/braille_pkg.sv
// Shared types, constants and the ASCII-to-braille mapping for the braille
// cell sequencer.
//
// Contents:
//   cell_t        6-bit braille cell, bit0 = dot1 ... bit5 = dot6, 1 = raised
//   seq_state_t   sequencer FSM states (IDLE, PREFIX, SHOW)
//   NUM_SIGN, SPACE_CELL, ERR_CELL   fixed cells
//   LETTER_TABLE  Grade-1 cells for 'a'..'z'
//   is_digit()    true for ASCII '0'..'9'
//   ascii_to_cell() maps one ASCII byte to its displayed cell
package braille_pkg;

    typedef logic [5:0] cell_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PREFIX = 2'd1,
        ST_SHOW   = 2'd2
    } seq_state_t;

    localparam cell_t NUM_SIGN   = 6'b111100;
    localparam cell_t SPACE_CELL = 6'b000000;
    localparam cell_t ERR_CELL   = 6'b111111;

    localparam cell_t LETTER_TABLE [0:25] = '{
        6'b000001, 6'b000011, 6'b001001, 6'b011001, 6'b010001, 6'b001011,
        6'b011011, 6'b010011, 6'b001010, 6'b011010, 6'b000101, 6'b000111,
        6'b001101, 6'b011101, 6'b010101, 6'b001111, 6'b011111, 6'b010111,
        6'b001110, 6'b011110, 6'b100101, 6'b100111, 6'b111010, 6'b101101,
        6'b111101, 6'b110101
    };

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    // Digits reuse the a..j cells: '1'..'9' map to a..i and '0' maps to j.
    // Letters are case-folded by forcing bit 5, which is valid only after the
    // byte has been confirmed to be in one of the two letter ranges.
    function automatic cell_t ascii_to_cell(input logic [7:0] c);
        logic [7:0] offset;
        logic [7:0] lower;
        cell_t      result;
        offset = 8'h00;
        lower  = c | 8'h20;
        result = ERR_CELL;
        if (is_digit(c)) begin
            if (c == 8'h30) begin
                result = LETTER_TABLE[9];
            end else begin
                offset = c - 8'h31;
                result = LETTER_TABLE[offset[4:0]];
            end
        end else if ((c >= 8'h61 && c <= 8'h7A) || (c >= 8'h41 && c <= 8'h5A)) begin
            offset = lower - 8'h61;
            result = LETTER_TABLE[offset[4:0]];
        end else if (c == 8'h20) begin
            result = SPACE_CELL;
        end
        return result;
    endfunction

endpackage

// File: rtl/braille_debounce.sv
// Button conditioning for the braille cell sequencer: a 2-flop synchronizer,
// a stability counter that commits a new level only after DEBOUNCE_CYCLES
// consecutive differing samples, and a single-cycle pulse on a committed
// 0->1 transition.
//
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   btn_raw  raw, asynchronous, bouncing button input
//   adv      one-cycle pulse per accepted press
module braille_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic adv
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync_1;
    logic             sync_2;
    logic             level;
    logic [CNT_W-1:0] stable_count;
    logic             flip;

    // The committed level flips on the last of DEBOUNCE_CYCLES consecutive
    // samples that disagree with it.
    assign flip = (sync_2 != level) && (stable_count == CNT_W'(DEBOUNCE_CYCLES - 1));

    // Two-stage synchronizer; the raw button has no relationship to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= btn_raw;
            sync_2 <= sync_1;
        end
    end

    // Any sample that agrees with the committed level restarts the count,
    // so a bouncing input never accumulates enough samples to flip.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_count <= '0;
            level        <= 1'b0;
            adv          <= 1'b0;
        end else begin
            adv <= 1'b0;
            if (sync_2 == level) begin
                stable_count <= '0;
            end else if (flip) begin
                stable_count <= '0;
                level        <= sync_2;
                adv          <= sync_2;
            end else begin
                stable_count <= stable_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/braille_cell_sequencer.sv
// Buffers ASCII characters in a small FIFO and presents one 6-dot braille
// cell at a time, advancing on each debounced press of the next button.
// A number sign is inserted before the first digit of every digit run.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   next_btn    raw "next" button
//   char_valid  write request for char_data
//   char_data   ASCII character to buffer
//   char_ready  FIFO can accept a write (not full)
//   cell_out    displayed braille dots, bit0 = dot1
//   cell_valid  cell_out holds a displayed cell
//   fifo_empty  no buffered characters
//   num_mode    number sign already issued for the current digit run
module braille_cell_sequencer
    import braille_pkg::*;
#(
    parameter int DEPTH           = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       next_btn,
    input  logic       char_valid,
    input  logic [7:0] char_data,
    output logic       char_ready,
    output logic [5:0] cell_out,
    output logic       cell_valid,
    output logic       fifo_empty,
    output logic       num_mode
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic             adv;

    logic [7:0]       fifo_mem [0:DEPTH-1];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             do_write;
    logic             do_pop;
    logic [7:0]       rd_data;

    seq_state_t       state;
    seq_state_t       state_next;
    cell_t            cell_next;
    logic             valid_next;
    logic             num_next;
    logic [7:0]       char_reg;
    logic [7:0]       char_next;

    braille_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_raw(next_btn),
        .adv    (adv)
    );

    assign fifo_full  = (fifo_count == CNT_W'(DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign char_ready = !fifo_full;
    assign do_write   = char_valid && !fifo_full;
    assign rd_data    = fifo_mem[rd_ptr];

    // Storage array has no reset; only the pointers and count define
    // which entries are meaningful.
    always_ff @(posedge clk) begin
        if (do_write) begin
            fifo_mem[wr_ptr] <= char_data;
        end
    end

    // Pointer and occupancy bookkeeping. A write and a pop in the same
    // cycle leave the count unchanged while both pointers advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_write, do_pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // State and all visible outputs are registered together so the
    // display changes exactly one cycle after an accepted press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cell_out   <= '0;
            cell_valid <= 1'b0;
            num_mode   <= 1'b0;
            char_reg   <= '0;
        end else begin
            state      <= state_next;
            cell_out   <= cell_next;
            cell_valid <= valid_next;
            num_mode   <= num_next;
            char_reg   <= char_next;
        end
    end

    // Next-state logic. IDLE and SHOW share the pop rule: a digit that
    // starts a new run is held in char_reg while the number sign is shown,
    // and PREFIX then shows the held digit without touching the FIFO.
    // Showing any cell records whether it was a digit, which both sets and
    // clears num_mode as digit runs begin and end.
    always_comb begin
        state_next = state;
        cell_next  = cell_out;
        valid_next = cell_valid;
        num_next   = num_mode;
        char_next  = char_reg;
        do_pop     = 1'b0;
        case (state)
            ST_IDLE, ST_SHOW: begin
                if (adv) begin
                    if (!fifo_empty) begin
                        do_pop     = 1'b1;
                        char_next  = rd_data;
                        valid_next = 1'b1;
                        if (is_digit(rd_data) && !num_mode) begin
                            state_next = ST_PREFIX;
                            cell_next  = NUM_SIGN;
                            num_next   = 1'b1;
                        end else begin
                            state_next = ST_SHOW;
                            cell_next  = ascii_to_cell(rd_data);
                            num_next   = is_digit(rd_data);
                        end
                    end else if (state == ST_SHOW) begin
                        state_next = ST_IDLE;
                        cell_next  = '0;
                        valid_next = 1'b0;
                        num_next   = 1'b0;
                    end
                end
            end
            ST_PREFIX: begin
                if (adv) begin
                    state_next = ST_SHOW;
                    cell_next  = ascii_to_cell(char_reg);
                    valid_next = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cell_next  = '0;
                valid_next = 1'b0;
                num_next   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_braille_cell_sequencer.sv
// Self-checking bench for braille_cell_sequencer. Characters written into
// the FIFO push their expected display sequence (including number signs)
// onto a scoreboard queue; each button press pops one entry and compares
// it with the registered outputs.
module tb_braille_cell_sequencer;

    logic       clk;
    logic       rst_n;
    logic       next_btn;
    logic       char_valid;
    logic [7:0] char_data;
    logic       char_ready;
    logic [5:0] cell_out;
    logic       cell_valid;
    logic       fifo_empty;
    logic       num_mode;

    int checks   = 0;
    int failures = 0;
    int adv_count = 0;
    int model_count = 0;
    bit model_num = 1'b0;

    // Entry layout: {pops_fifo, num_mode, cell_valid, cell[5:0]}
    logic [8:0] exp_q [$];

    localparam logic [5:0] TB_LETTERS [0:25] = '{
        6'b000001, 6'b000011, 6'b001001, 6'b011001, 6'b010001, 6'b001011,
        6'b011011, 6'b010011, 6'b001010, 6'b011010, 6'b000101, 6'b000111,
        6'b001101, 6'b011101, 6'b010101, 6'b001111, 6'b011111, 6'b010111,
        6'b001110, 6'b011110, 6'b100101, 6'b100111, 6'b111010, 6'b101101,
        6'b111101, 6'b110101
    };

    braille_cell_sequencer #(
        .DEPTH(8),
        .DEBOUNCE_CYCLES(16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .next_btn  (next_btn),
        .char_valid(char_valid),
        .char_data (char_data),
        .char_ready(char_ready),
        .cell_out  (cell_out),
        .cell_valid(cell_valid),
        .fifo_empty(fifo_empty),
        .num_mode  (num_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count internal advance pulses to verify one pulse per press.
    always @(posedge clk) begin
        if (dut.adv === 1'b1) adv_count++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    function automatic bit tbIsDigit(input byte c);
        return (c >= "0") && (c <= "9");
    endfunction

    function automatic logic [5:0] modelCell(input byte c);
        byte lc;
        if (c == "0") return TB_LETTERS[9];
        if (tbIsDigit(c)) return TB_LETTERS[c - "1"];
        if (c >= "A" && c <= "Z") begin
            lc = c - "A";
            return TB_LETTERS[lc];
        end
        if (c >= "a" && c <= "z") begin
            lc = c - "a";
            return TB_LETTERS[lc];
        end
        if (c == " ") return 6'b000000;
        return 6'b111111;
    endfunction

    task automatic writeChar(input byte c);
        bit exp_ready;
        @(negedge clk);
        exp_ready = (model_count < 8);
        checkOutput("char_ready", {31'd0, char_ready}, {31'd0, exp_ready});
        char_valid = 1'b1;
        char_data  = c;
        @(posedge clk);
        @(negedge clk);
        char_valid = 1'b0;
        if (exp_ready) begin
            model_count++;
            if (tbIsDigit(c) && !model_num) begin
                exp_q.push_back({1'b1, 1'b1, 1'b1, 6'b111100});
                exp_q.push_back({1'b0, 1'b1, 1'b1, modelCell(c)});
                model_num = 1'b1;
            end else begin
                model_num = tbIsDigit(c);
                exp_q.push_back({1'b1, model_num, 1'b1, modelCell(c)});
            end
        end
    endtask

    task automatic applyStimulus(input string s);
        for (int i = 0; i < s.len(); i++) begin
            writeChar(s[i]);
        end
    endtask

    // One press, either clean or preceded by 100 cycles of bounce; then
    // the scoreboard entry for this press is compared with the outputs.
    task automatic pressNext(input bit bounce);
        int         adv_before;
        logic [8:0] exp;
        adv_before = adv_count;
        if (bounce) begin
            for (int i = 0; i < 20; i++) begin
                next_btn = ~next_btn;
                repeat (5) @(negedge clk);
            end
        end
        next_btn = 1'b1;
        repeat (30) @(negedge clk);
        next_btn = 1'b0;
        repeat (30) @(negedge clk);
        checkOutput("adv_pulses", adv_count - adv_before, 1);
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            if (exp[8]) model_count--;
        end else begin
            exp = 9'd0;
            model_num = 1'b0;
        end
        checkOutput("cell_out", {26'd0, cell_out}, {26'd0, exp[5:0]});
        checkOutput("cell_valid", {31'd0, cell_valid}, {31'd0, exp[6]});
        checkOutput("num_mode", {31'd0, num_mode}, {31'd0, exp[7]});
        checkOutput("fifo_empty", {31'd0, fifo_empty}, {31'd0, model_count == 0});
    endtask

    initial begin
        rst_n      = 1'b0;
        next_btn   = 1'b0;
        char_valid = 1'b0;
        char_data  = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("rst_cell_out", {26'd0, cell_out}, 0);
        checkOutput("rst_cell_valid", {31'd0, cell_valid}, 0);
        checkOutput("rst_num_mode", {31'd0, num_mode}, 0);
        checkOutput("rst_fifo_empty", {31'd0, fifo_empty}, 1);
        checkOutput("rst_char_ready", {31'd0, char_ready}, 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] single letter");
        applyStimulus("a");
        pressNext(1'b0);
        pressNext(1'b0);

        $display("[TB] letter then digit with prefix");
        applyStimulus("A1");
        repeat (4) pressNext(1'b0);

        $display("[TB] digit runs split by space");
        applyStimulus("12 3");
        repeat (7) pressNext(1'b0);

        $display("[TB] bouncing button");
        applyStimulus("kl");
        pressNext(1'b0);
        pressNext(1'b1);
        pressNext(1'b0);

        $display("[TB] FIFO full");
        applyStimulus("abcdefghi");
        checkOutput("full_char_ready", {31'd0, char_ready}, 0);
        repeat (9) pressNext(1'b0);

        $display("[TB] async reset while showing");
        applyStimulus("~b");
        pressNext(1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_cell_out", {26'd0, cell_out}, 0);
        checkOutput("async_cell_valid", {31'd0, cell_valid}, 0);
        checkOutput("async_num_mode", {31'd0, num_mode}, 0);
        checkOutput("async_fifo_empty", {31'd0, fifo_empty}, 1);
        checkOutput("async_char_ready", {31'd0, char_ready}, 1);
        exp_q.delete();
        model_count = 0;
        model_num   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        pressNext(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
